// File: rtl/mdu_issue_if.sv
// mdu_issue_if: E-stage MD-op request, pipeline stall and unit issue bundle.
// master drives the request side; slave is the issue controller.
interface mdu_issue_if;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        flush;
    logic        mdu_busy;
    logic        stall;
    logic        mdu_start;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic [31:0] stall_cnt;

    modport master (
        output in_valid, in_op, in_a, in_b, flush, mdu_busy,
        input  stall, mdu_start, mdu_op, mdu_a, mdu_b, stall_cnt
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, flush, mdu_busy,
        output stall, mdu_start, mdu_op, mdu_a, mdu_b, stall_cnt
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issues MD-class ops to the multiply/divide unit and stalls while it is busy.
// Define MDU_ISSUE_PERF_EN to build the saturating stall-cycle counter; otherwise stall_cnt is 0.
module mdu_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_issue_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          legal, accept, long_op;

    assign legal     = bus.in_op inside {[4'd1:4'd8]};
    assign long_op   = bus.in_op <= 4'd4;
    assign bus.stall = bus.in_valid & legal & ((state == BUSY) | bus.mdu_busy);
    assign accept    = bus.in_valid & legal & ~bus.flush & ~bus.stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.mdu_start <= 1'b0;
            bus.mdu_op    <= '0;
            bus.mdu_a     <= '0;
            bus.mdu_b     <= '0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            bus.mdu_start <= accept;
            if (accept) begin
                bus.mdu_op <= bus.in_op;
                bus.mdu_a  <= bus.in_a;
                bus.mdu_b  <= bus.in_b;
            end
        end
    end

    // Flush is ignored once BUSY: an issued op always runs its full latency.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (state == IDLE) begin
            if (accept && long_op) begin
                state_d = BUSY;
                cnt_d   = (bus.in_op <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end
        end else begin
            cnt_d   = cnt - 1'b1;
            state_d = (cnt == CW'(1)) ? IDLE : BUSY;
        end
    end

`ifdef MDU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)
            bus.stall_cnt <= '0;
        else if (bus.stall && bus.stall_cnt != '1)
            bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: directed and randomized checks of mdu_issue_ctrl against a
// busy-until-cycle reference model.
module tb_mdu_issue_ctrl;
    localparam int MULT = 5;
    localparam int DIV  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   free_at = 0;
    logic obs_stall;
    logic        m_start;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_cnt;

    mdu_issue_if bus();

    mdu_issue_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational stall, then registered outputs after the edge.
    task automatic cycle(input logic r, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input logic bz);
        logic lg, es, acc;
        reset = r;
        bus.in_valid = v;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        bus.flush = fl;
        bus.mdu_busy = bz;
        #2;
        obs_stall = bus.stall;
        lg = (op >= 4'd1) && (op <= 4'd8);
        es = v && lg && ((cyc < free_at) || bz);
        chk("stall", {31'd0, bus.stall}, {31'd0, es});
        acc = v && lg && !fl && !es;
        if (r) begin
            m_start = 1'b0;
            m_op = '0;
            m_a = '0;
            m_b = '0;
            m_cnt = '0;
            free_at = cyc + 1;
        end else begin
            m_start = acc;
            if (acc) begin
                m_op = op;
                m_a = a;
                m_b = b;
                if (op <= 4'd4) free_at = cyc + 1 + ((op <= 4'd2) ? MULT : DIV);
            end
`ifdef MDU_ISSUE_PERF_EN
            if (es && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
`endif
        end
        cyc++;
        @(posedge clk);
        #1;
        chk("mdu_start", {31'd0, bus.mdu_start}, {31'd0, m_start});
        chk("mdu_op", {28'd0, bus.mdu_op}, {28'd0, m_op});
        chk("mdu_a", bus.mdu_a, m_a);
        chk("mdu_b", bus.mdu_b, m_b);
        chk("stall_cnt", bus.stall_cnt, m_cnt);
    endtask

    // Hold an MD op on the bus until it is accepted; returns the stalled cycle count.
    task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        stalls = 0;
        cycle(1'b0, 1'b1, op, a, b, 1'b0, 1'b0);
        while (obs_stall && stalls < 40) begin
            stalls++;
            cycle(1'b0, 1'b1, op, a, b, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        logic [3:0] op;
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.flush = 1'b0;
        bus.mdu_busy = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 4'd0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'd0, 0, 0, 1'b0, 1'b0);
        chk("reset_start", {31'd0, bus.mdu_start}, 32'd0);
        chk("reset_cnt", bus.stall_cnt, 32'd0);
        cycle(1'b0, 1'b0, 4'd0, 0, 0, 1'b0, 1'b0);

        cycle(1'b0, 1'b1, 4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        chk("mult_start", {31'd0, bus.mdu_start}, 32'd1);
        chk("mult_op", {28'd0, bus.mdu_op}, 32'd1);
        offer(4'd6, 32'd0, 32'd0, n);
        chk("mult_stalls", n, MULT);
        chk("mflo_start", {31'd0, bus.mdu_start}, 32'd1);

        cycle(1'b0, 1'b1, 4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
        offer(4'd5, 32'd0, 32'd0, n);
        chk("div_stalls", n, DIV);
        chk("mfhi_start", {31'd0, bus.mdu_start}, 32'd1);

        cycle(1'b0, 1'b1, 4'd7, 32'h11, 32'd0, 1'b0, 1'b0);
        chk("mthi_start", {31'd0, bus.mdu_start}, 32'd1);
        cycle(1'b0, 1'b1, 4'd8, 32'h22, 32'd0, 1'b0, 1'b0);
        chk("mtlo_start", {31'd0, bus.mdu_start}, 32'd1);
        chk("mtlo_a", bus.mdu_a, 32'h22);

        cycle(1'b0, 1'b1, 4'd1, 32'd9, 32'd9, 1'b1, 1'b0);
        chk("flush_nostart", {31'd0, bus.mdu_start}, 32'd0);
        cycle(1'b0, 1'b1, 4'd6, 0, 0, 1'b0, 1'b0);
        chk("flush_idle", {31'd0, obs_stall}, 32'd0);

        cycle(1'b0, 1'b1, 4'd3, 32'd55, 32'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'd5, 0, 0, 1'b1, 1'b0);
        offer(4'd5, 0, 0, n);
        chk("flush_busy_stalls", n, DIV - 4);

        cycle(1'b0, 1'b1, 4'd3, 32'd8, 32'd2, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'd6, 32'd1, 32'd1, 1'b0, 1'b0);
        chk("rst_op", {28'd0, bus.mdu_op}, 32'd0);
        chk("rst_a", bus.mdu_a, 32'd0);
        cycle(1'b0, 1'b1, 4'd6, 0, 0, 1'b0, 1'b0);
        chk("rst_nostall", {31'd0, obs_stall}, 32'd0);

        cycle(1'b0, 1'b1, 4'hF, 32'd1, 32'd2, 1'b0, 1'b0);
        chk("illegal_stall", {31'd0, obs_stall}, 32'd0);
        chk("illegal_start", {31'd0, bus.mdu_start}, 32'd0);

        cycle(1'b0, 1'b1, 4'd6, 0, 0, 1'b0, 1'b1);
        chk("busy_stall", {31'd0, obs_stall}, 32'd1);
        cycle(1'b0, 1'b1, 4'd6, 0, 0, 1'b0, 1'b0);
        chk("busy_release", {31'd0, bus.mdu_start}, 32'd1);

        for (int i = 0; i < 500; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, op, $urandom, $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
